// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer owning the program counter.
//
// Drives a single-outstanding req/gnt/rvalid instruction-memory port, applies
// branch (PCSrc/branch_target) and trap redirects, holds the fetched
// instruction while decode stalls, and discards responses made stale by a
// redirect taken while the transaction was in flight.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   stall          decode cannot accept; if_* outputs hold
//   PCSrc          branch/jump taken this cycle
//   branch_target  redirect target (bits [1:0] forced to 0)
//   trap           trap redirect, priority over PCSrc
//   imem_req       registered fetch request
//   imem_addr      fetch address (equals pc_curr)
//   imem_gnt       memory accepts the address this cycle
//   imem_rvalid    response valid
//   imem_rdata     response instruction
//   pc_curr        PC of the current or next fetch
//   if_valid       if_instr/if_pc hold a valid instruction
//   if_instr       fetched instruction
//   if_pc          address of if_instr
module fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        PCSrc,
    input  logic [31:0] branch_target,
    input  logic        trap,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_curr,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic        kill_q, kill_d;

    logic        redirect;
    logic [31:0] target;

    assign redirect = trap | PCSrc;
    assign target   = trap ? TRAP_VECTOR : (branch_target & 32'hFFFF_FFFC);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        kill_d  = kill_q;

        // Consumption and flush both retire the held instruction; a load in
        // WAIT below overrides this.
        if (valid_q && (!stall || redirect)) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect) pc_d = target;
            end
            REQ: begin
                if (redirect) pc_d = target;
                if (imem_gnt) begin
                    state_d = WAIT;
                    // Granted address is already stale if redirected now.
                    kill_d  = redirect;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q || redirect) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                        if (redirect) pc_d = target;
                    end else begin
                        instr_d = imem_rdata;
                        ifpc_d  = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 32'd4;
                        state_d = stall ? HOLD : REQ;
                    end
                end else if (redirect) begin
                    pc_d   = target;
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect || !stall) begin
                    state_d = REQ;
                    if (redirect) pc_d = target;
                end
            end
            default: state_d = IDLE;
        endcase

        req_d = (state_d == REQ);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_VECTOR;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= NOP;
            ifpc_q  <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            kill_q  <= kill_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign pc_curr   = pc_q;
    assign if_valid  = valid_q;
    assign if_instr  = instr_q;
    assign if_pc     = ifpc_q;

endmodule
